// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: command codes decoded by the CU,
// FSM states and small op-classification helpers.
package mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6
  } mdOp_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mduState_e;

  // Ops that occupy the unit for a busy period and commit HI/LO at the end
  function automatic logic isLongOp(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic isDivOp(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing the HI/LO pair for one MD command,
// including the signed-overflow and divide-by-zero rules.
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             divByZero_o
);

  logic signed [2*WIDTH-1:0] prodS;
  logic        [2*WIDTH-1:0] prodU;
  logic signed [WIDTH-1:0]   aS, dS, quotS, remS;
  logic        [WIDTH-1:0]   dU, quotU, remU;
  logic                      bZero, sOvf;

  assign bZero = (b_i == '0);
  assign sOvf  = (a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (b_i == '1);

  assign prodS = $signed({{WIDTH{a_i[WIDTH-1]}}, a_i}) * $signed({{WIDTH{b_i[WIDTH-1]}}, b_i});
  assign prodU = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

  // A divisor of 1 replaces zero and the MIN/-1 overflow case: it yields quotient A, remainder 0
  assign aS    = $signed(a_i);
  assign dS    = (bZero || sOvf) ? $signed({{(WIDTH-1){1'b0}}, 1'b1}) : $signed(b_i);
  assign quotS = aS / dS;
  assign remS  = aS % dS;

  assign dU    = bZero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_i;
  assign quotU = a_i / dU;
  assign remU  = a_i % dU;

  always_comb begin
    hi_o        = '0;
    lo_o        = '0;
    divByZero_o = 1'b0;
    case (op_i)
      MD_MULT:  {hi_o, lo_o} = prodS;
      MD_MULTU: {hi_o, lo_o} = prodU;
      MD_DIV: begin
        hi_o        = remS;
        lo_o        = quotS;
        divByZero_o = bZero;
      end
      MD_DIVU: begin
        hi_o        = remU;
        lo_o        = quotU;
        divByZero_o = bZero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// E-stage multiply/divide unit: owns HI/LO, models an iterative unit with a fixed busy
// latency per op class, and raises the D-stage stall for dependent MD instructions.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             d_md_use,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             md_stall
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef logic [CW-1:0] cnt_t;

  mduState_e        state_q, state_d;
  cnt_t             count_q, count_d;
  logic [WIDTH-1:0] hiT_q, hiT_d, loT_q, loT_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] arHi, arLo;
  logic             arDivByZero;

  mdu_arith #(.WIDTH(WIDTH)) uArith (
    .op_i        (op),
    .a_i         (A),
    .b_i         (B),
    .hi_o        (arHi),
    .lo_o        (arLo),
    .divByZero_o (arDivByZero)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hiT_d   = hiT_q;
    loT_d   = loT_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (isLongOp(op)) begin
            // Divide by zero latches the current HI/LO so the commit leaves them unchanged
            hiT_d   = arDivByZero ? hi_q : arHi;
            loT_d   = arDivByZero ? lo_q : arLo;
            count_d = isDivOp(op) ? cnt_t'(DIV_CYCLES) : cnt_t'(MULT_CYCLES);
            state_d = ST_RUN;
          end else if (op == MD_MTHI) begin
            hi_d = A;
          end else if (op == MD_MTLO) begin
            lo_d = A;
          end
        end
      end
      ST_RUN: begin
        if (count_q <= cnt_t'(1)) begin
          count_d = '0;
          hi_d    = hiT_q;
          lo_d    = loT_q;
          state_d = ST_IDLE;
        end else begin
          count_d = count_q - cnt_t'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      hiT_q   <= '0;
      loT_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hiT_q   <= hiT_d;
      loT_q   <= loT_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign md_stall = d_md_use & (start | busy);

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes expected HI/LO results from an arithmetic
// reference model; a negedge monitor pops and compares when the unit commits.
module tb_mdu;
  import mdu_pkg::*;

  localparam int WIDTH  = 32;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        d_md_use = 1'b0;
  logic        busy, md_stall;
  logic [31:0] hi, lo;

  mdu #(.WIDTH(WIDTH), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .A        (A),
    .B        (B),
    .d_md_use (d_md_use),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo),
    .md_stall (md_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
    string       name;
  } exp_t;

  exp_t        sbQ[$];
  exp_t        stateQ[$];
  int          nChecks = 0;
  int          nFails = 0;
  int          cycleCount = 0;
  int          busyEnd = 0;
  int          busyCnt = 0;
  int          doneCycle = 0;
  bit          prevBusy = 1'b0;
  bit          checkEn = 1'b0;
  bit          done = 1'b0;
  bit          expBusy;
  logic [31:0] modelHi = '0;
  logic [31:0] modelLo = '0;

  // Architectural reference: plain 64-bit arithmetic on the MIPS HI/LO rules
  task automatic modelOp(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output bit isLong, output int n);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur, up;
    logic [63:0]     sp;
    isLong = 1'b0;
    n = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    case (o)
      MD_MULT: begin
        sp = 64'(sa * sb);
        modelHi = sp[63:32]; modelLo = sp[31:0];
        isLong = 1'b1; n = MULT_N;
      end
      MD_MULTU: begin
        up = ua * ub;
        modelHi = up[63:32]; modelLo = up[31:0];
        isLong = 1'b1; n = MULT_N;
      end
      MD_DIV: begin
        isLong = 1'b1; n = DIV_N;
        if (b != 0) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            modelLo = a; modelHi = '0;
          end else begin
            q = sa / sb;
            r = sa - q * sb;
            modelLo = q[31:0]; modelHi = r[31:0];
          end
        end
      end
      MD_DIVU: begin
        isLong = 1'b1; n = DIV_N;
        if (b != 0) begin
          uq = ua / ub;
          ur = ua - uq * ub;
          modelLo = uq[31:0]; modelHi = ur[31:0];
        end
      end
      MD_MTHI: modelHi = a;
      MD_MTLO: modelLo = a;
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    d_md_use = 1'($urandom_range(0, 1));
  endtask

  task automatic applyStimulus(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                               input string name);
    bit isLong;
    int n;
    int guard = 0;
    while (cycleCount < busyEnd && guard < 100) begin
      tick();
      guard++;
    end
    start = 1'b1; op = o; A = a; B = b;
    tick();
    start = 1'b0;
    op = 4'($urandom_range(0, 15));
    A = $urandom();
    B = $urandom();
    modelOp(o, a, b, isLong, n);
    if (isLong) begin
      busyEnd = cycleCount + n;
      sbQ.push_back('{modelHi, modelLo, n, name});
    end else begin
      stateQ.push_back('{modelHi, modelLo, 0, name});
    end
  endtask

  function automatic logic [31:0] pickVal();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: per-cycle busy/stall checks, state checks, and scoreboard pop on commit
  always @(negedge clk) begin
    exp_t e;
    cycleCount++;
    if (checkEn) begin
      expBusy = (cycleCount <= busyEnd);
      checkOutput("busy", 32'(busy), 32'(expBusy));
      checkOutput("md_stall", 32'(md_stall), 32'(d_md_use & (start | expBusy)));
      if (stateQ.size() > 0) begin
        e = stateQ.pop_front();
        checkOutput({e.name, "_hi"}, hi, e.hi);
        checkOutput({e.name, "_lo"}, lo, e.lo);
      end
      if (busy) begin
        busyCnt++;
      end else if (prevBusy) begin
        if (sbQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL spurious_commit: actual busy period %0d required none", busyCnt);
        end else begin
          e = sbQ.pop_front();
          checkOutput({e.name, "_hi"}, hi, e.hi);
          checkOutput({e.name, "_lo"}, lo, e.lo);
          checkOutput({e.name, "_len"}, 32'(busyCnt), 32'(e.len));
        end
        busyCnt = 0;
      end
      prevBusy = busy;
    end
    if ((done && ((sbQ.size() == 0 && stateQ.size() == 0) || cycleCount > doneCycle + 50))
        || cycleCount > 20000) begin
      if (cycleCount > 20000) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL watchdog: actual cycle %0d required completion", cycleCount);
      end
      while (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        nChecks++;
        nFails++;
        $display("[TB] FAIL %s_commit: actual none required a commit", e.name);
      end
      while (stateQ.size() > 0) begin
        e = stateQ.pop_front();
        nChecks++;
        nFails++;
        $display("[TB] FAIL %s_state: actual unchecked required a check", e.name);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
    end
  end

  initial begin
    logic [3:0]  o;
    logic [31:0] a, b;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    checkEn = 1'b1;
    stateQ.push_back('{32'h0, 32'h0, 0, "reset"});

    applyStimulus(MD_MULT,  32'hFFFF_FFFF, 32'h0000_0002, "mult_neg1x2");
    applyStimulus(MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, "multu_max_x2");
    applyStimulus(MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, "div_m7_2");
    applyStimulus(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    applyStimulus(MD_MTHI,  32'h0000_1234, 32'h0,         "mthi");
    applyStimulus(MD_MTLO,  32'h0000_5678, 32'h0,         "mtlo");
    applyStimulus(MD_DIVU,  32'h0000_9999, 32'h0,         "divu_zero");
    applyStimulus(MD_DIV,   32'h0000_0064, 32'h0,         "div_zero");
    applyStimulus(MD_NONE,  32'hDEAD_BEEF, 32'h1,         "none");
    applyStimulus(4'd9,     32'hDEAD_BEEF, 32'h1,         "undef_op");

    // A start during the busy period must not disturb the pending result
    applyStimulus(MD_DIVU, 32'h0000_0064, 32'h0000_0007, "divu_ignored");
    tick();
    start = 1'b1; op = MD_MTHI; A = 32'hCAFE_F00D;
    tick();
    start = 1'b0;

    // Abort: MULT, ignored MTLO at busy cycle 2, reset at busy cycle 3
    applyStimulus(MD_MULT, 32'h1234_5678, 32'h9ABC_DEF0, "abort_mult");
    tick();
    start = 1'b1; op = MD_MTLO; A = 32'h0000_AAAA;
    tick();
    start = 1'b0;
    reset = 1'b1;
    sbQ.delete(sbQ.size() - 1);
    sbQ.push_back('{32'h0, 32'h0, 3, "abort"});
    modelHi = '0;
    modelLo = '0;
    tick();
    reset = 1'b0;
    busyEnd = cycleCount;
    stateQ.push_back('{32'h0, 32'h0, 0, "reset_abort"});
    repeat (7) tick();
    stateQ.push_back('{32'h0, 32'h0, 0, "no_commit"});
    tick();

    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(0, 15));
      if (o > 4'd8) o = 4'($urandom_range(1, 6));
      a = pickVal();
      b = pickVal();
      if ($urandom_range(0, 5) == 0) b = 32'h0;
      if ($urandom_range(0, 9) == 0) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      applyStimulus(o, a, b, $sformatf("rand%0d_op%0d", i, o));
      repeat ($urandom_range(0, 2)) tick();
    end

    while (cycleCount < busyEnd) tick();
    repeat (2) tick();
    doneCycle = cycleCount;
    done = 1'b1;
  end

endmodule

// File: doc/mdu.md
# mdu

Parametrised multiply/divide unit for the pipelined MIPS core, the successor to the single-cycle datapath's purely combinational control. It sits beside the ALU in the E stage and owns the HI/LO register pair. It accepts one mult/multu/div/divu/mthi/mtlo command per start pulse and models a multi-cycle iterative unit with a configurable busy latency. It also drives the D-stage stall request for any instruction that touches the unit.

## Interface
- `WIDTH`, 32: operand width. HI and LO are `WIDTH` bits each; the product is `2*WIDTH` bits.
- `MULT_CYCLES`, 5: busy cycles for mult/multu. Must be at least 1.
- `DIV_CYCLES`, 10: busy cycles for div/divu. Must be at least 1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: E-stage instruction is an MD command this cycle.
- `op` in 4: command code from `mdu_pkg`; sampled only when `start`=1.
- `A` in `WIDTH`: rs operand (dividend / multiplicand / mthi-mtlo source).
- `B` in `WIDTH`: rt operand.
- `d_md_use` in 1: the D-stage instruction is an MD command or mfhi/mflo.
- `busy` out 1: an operation is in flight.
- `hi` out `WIDTH`: HI register, read directly by mfhi.
- `lo` out `WIDTH`: LO register, read directly by mflo.
- `md_stall` out 1: combinational, equals `d_md_use & (start | busy)`.

## Operation
- Reset values: `hi`=0, `lo`=0, `busy`=0, internal counter=0, result temporaries=0.
- FSM states:
  - IDLE: `busy`=0.
  - RUN: `busy`=1; counter holds the remaining cycles.
- IDLE with `start`=1 and op MULT, MULTU, DIV or DIVU:
  - Latch the result into `hi_t`/`lo_t` at this edge.
  - Load the counter with `MULT_CYCLES` or `DIV_CYCLES`; go to RUN.
- IDLE with `start`=1 and op MTHI or MTLO:
  - Write `A` into `hi` or `lo` at this edge.
  - No busy period.
- RUN: decrement the counter each edge. On the edge where the counter reaches 0:
  - Commit `hi_t`→`hi` and `lo_t`→`lo`.
  - Deassert `busy`; return to IDLE.
- `start` while in RUN: ignored, including mthi/mtlo. `md_stall` guarantees this never occurs in the core; the bench checks that it is harmless anyway.
- MD_NONE or undefined op with `start`=1: no effect.
- MULT: signed `A*B`; `hi`=upper `WIDTH` bits, `lo`=lower `WIDTH` bits.
- MULTU: same, with unsigned operands.
- DIV (signed):
  - `lo` = quotient truncated toward zero; `hi` = remainder, which takes the dividend's sign.
  - Overflow case (`A` = most-negative, `B` = −1): `lo`=`A`, `hi`=0.
- DIVU: unsigned; `lo`=quotient, `hi`=remainder.
- `B`=0 on DIV/DIVU: the full busy period still runs, but `hi`/`lo` are left unchanged at commit.
- `reset` mid-operation: it wins over everything; all state returns to reset values on that edge and the pending result is discarded.

## Timing
- Start sampled at edge T0.
- `busy`=1 during the N cycles after T0.
- `hi`/`lo` change at edge T0+N, and `busy`=0 in the same cycle the new values appear. N is `MULT_CYCLES` or `DIV_CYCLES`.
- mthi/mtlo: the new value is visible in the cycle after the start edge.
- A back-to-back MD command can start on the first cycle after `busy` falls.
- `md_stall` has zero latency (combinational). It is high in the start cycle itself, so a dependent mfhi in D stalls correctly.

## Structure
- Shared package `mdu_pkg`:
  - Op codes: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6.
  - FSM state constants.
  - The CU decodes into these codes in place of its local defines.
- One natural sub-module, `mdu_arith`: combinational signed/unsigned multiply and divide, including the divide-by-zero and overflow rules. `mdu` keeps the FSM, counter, temporaries and HI/LO.

## Test plan
- MULT, `A`=0xFFFFFFFF, `B`=2 → `busy` high exactly 5 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE.
- MULTU with the same operands → `hi`=0x00000001, `lo`=0xFFFFFFFE.
- DIV, `A`=0xFFFFFFF9 (−7), `B`=2 → after 10 busy cycles, `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIV, `A`=0x80000000, `B`=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU with `B`=0, after MTHI 0x1234 and MTLO 0x5678 → 10 busy cycles, then `hi`=0x1234 and `lo`=0x5678 unchanged.
- MULT started, a second start (MTLO 0xAAAA) issued at busy cycle 2, then `reset` at busy cycle 3 → the second start has no effect; on the reset edge `busy`=0 and `hi`=`lo`=0, and no commit follows. `md_stall`=1 whenever `d_md_use`=1 during start/busy.
